// File: rtl/duck_round_ctrl_if.sv
// duck_round_ctrl_if
// Bundles the game-flow controller's event inputs and status outputs.
//   master : drives frame_tick/start/shot/hit, observes the status outputs
//            (aim/trigger logic, timing generator, or a testbench)
//   slave  : the controller itself
// Signals:
//   frame_tick   one-cycle pulse per video frame (vblank start)
//   start        one-cycle debounced start-button pulse
//   shot         one-cycle trigger pulse
//   hit          qualifies shot in the same cycle
//   duck_spawn   one-cycle pulse, duck loads its start position
//   duck_active  duck is flying and can be shot
//   duck_falling hit animation phase
//   dog_show     escape/laugh animation phase
//   shots_left   remaining shots for the current duck
//   duck_idx     0-based duck index within the round
//   hits         ducks hit in the current round
//   round        round number 1..99
//   game_over    game-over screen request
interface duck_round_ctrl_if;
  logic       frame_tick;
  logic       start;
  logic       shot;
  logic       hit;
  logic       duck_spawn;
  logic       duck_active;
  logic       duck_falling;
  logic       dog_show;
  logic [1:0] shots_left;
  logic [3:0] duck_idx;
  logic [3:0] hits;
  logic [6:0] round;
  logic       game_over;

  modport master (
    output frame_tick, start, shot, hit,
    input  duck_spawn, duck_active, duck_falling, dog_show,
    input  shots_left, duck_idx, hits, round, game_over
  );

  modport slave (
    input  frame_tick, start, shot, hit,
    output duck_spawn, duck_active, duck_falling, dog_show,
    output shots_left, duck_idx, hits, round, game_over
  );
endinterface

// File: rtl/duck_round_ctrl.sv
// duck_round_ctrl
// Game-flow controller for the Duck Hunt VGA design. Sequences each duck
// through spawn, flight, fall/escape and each round through its duck count,
// paced by one frame tick per video frame.
// Ports:
//   clk65 : 65 MHz pixel clock
//   rst   : synchronous active-high reset
//   bus   : duck_round_ctrl_if.slave (event inputs, registered status outputs)
module duck_round_ctrl #(
  parameter int DUCKS_PER_ROUND = 10,
  parameter int SHOTS_PER_DUCK  = 3,
  parameter int MIN_HITS        = 6,
  parameter int FLY_FRAMES      = 300,
  parameter int PAUSE_FRAMES    = 60
) (
  input  logic              clk65,
  input  logic              rst,
  duck_round_ctrl_if.slave  bus
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INTRO     = 3'd1;
  localparam logic [2:0] ST_SPAWN     = 3'd2;
  localparam logic [2:0] ST_FLY       = 3'd3;
  localparam logic [2:0] ST_FALL      = 3'd4;
  localparam logic [2:0] ST_ESCAPE    = 3'd5;
  localparam logic [2:0] ST_NEXT      = 3'd6;
  localparam logic [2:0] ST_GAME_OVER = 3'd7;

  // Terminal counts: the state is left on the tick that arrives while the
  // counter already holds N-1, i.e. on the Nth tick seen in that state.
  localparam logic [11:0] PAUSE_LAST = 12'(PAUSE_FRAMES - 1);
  localparam logic [11:0] FLY_LAST   = 12'(FLY_FRAMES - 1);
  localparam logic [3:0]  LAST_IDX   = 4'(DUCKS_PER_ROUND - 1);
  localparam logic [3:0]  HITS_REQ   = 4'(MIN_HITS);
  localparam logic [1:0]  SHOTS_INIT = 2'(SHOTS_PER_DUCK);
  localparam logic [6:0]  ROUND_MAX  = 7'd99;

  logic [2:0]  state_reg, state_next;
  logic [11:0] frame_cnt_reg, frame_cnt_next;
  logic [1:0]  shots_left_reg, shots_left_next;
  logic [3:0]  duck_idx_reg, duck_idx_next;
  logic [3:0]  hits_reg, hits_next;
  logic [6:0]  round_reg, round_next;
  logic        duck_spawn_reg, duck_active_reg, duck_falling_reg;
  logic        dog_show_reg, game_over_reg;
  logic        pause_done, fly_done, waiting;

  assign pause_done = bus.frame_tick && (frame_cnt_reg == PAUSE_LAST);
  assign fly_done   = bus.frame_tick && (frame_cnt_reg == FLY_LAST);
  assign waiting    = (state_reg == ST_INTRO) || (state_reg == ST_FLY) ||
                      (state_reg == ST_FALL)  || (state_reg == ST_ESCAPE);

  always_comb begin
    state_next      = state_reg;
    shots_left_next = shots_left_reg;
    duck_idx_next   = duck_idx_reg;
    hits_next       = hits_reg;
    round_next      = round_reg;

    case (state_reg)
      ST_IDLE, ST_GAME_OVER: begin
        if (bus.start) begin
          state_next    = ST_INTRO;
          hits_next     = 4'd0;
          duck_idx_next = 4'd0;
          round_next    = 7'd1;
        end
      end
      ST_INTRO: begin
        if (pause_done) state_next = ST_SPAWN;
      end
      ST_SPAWN: begin
        shots_left_next = SHOTS_INIT;
        state_next      = ST_FLY;
      end
      ST_FLY: begin
        if (bus.shot) begin
          if (shots_left_reg != 2'd0) shots_left_next = shots_left_reg - 2'd1;
          // A hit beats a simultaneous timeout; a miss on the last shot or
          // on the timeout tick sends the duck away.
          if (bus.hit) begin
            hits_next  = hits_reg + 4'd1;
            state_next = ST_FALL;
          end else if (shots_left_reg <= 2'd1 || fly_done) begin
            state_next = ST_ESCAPE;
          end
        end else if (fly_done) begin
          state_next = ST_ESCAPE;
        end
      end
      ST_FALL, ST_ESCAPE: begin
        if (pause_done) state_next = ST_NEXT;
      end
      ST_NEXT: begin
        if (duck_idx_reg < LAST_IDX) begin
          duck_idx_next = duck_idx_reg + 4'd1;
          state_next    = ST_SPAWN;
        end else if (hits_reg >= HITS_REQ) begin
          round_next    = (round_reg < ROUND_MAX) ? round_reg + 7'd1 : ROUND_MAX;
          hits_next     = 4'd0;
          duck_idx_next = 4'd0;
          state_next    = ST_INTRO;
        end else begin
          state_next = ST_GAME_OVER;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Clearing on the transition cycle means a tick coinciding with entry
    // is never credited to the new state.
    if (state_next != state_reg)
      frame_cnt_next = 12'd0;
    else if (waiting && bus.frame_tick)
      frame_cnt_next = frame_cnt_reg + 12'd1;
    else
      frame_cnt_next = frame_cnt_reg;
  end

  always_ff @(posedge clk65) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      frame_cnt_reg    <= 12'd0;
      shots_left_reg   <= 2'd0;
      duck_idx_reg     <= 4'd0;
      hits_reg         <= 4'd0;
      round_reg        <= 7'd1;
      duck_spawn_reg   <= 1'b0;
      duck_active_reg  <= 1'b0;
      duck_falling_reg <= 1'b0;
      dog_show_reg     <= 1'b0;
      game_over_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      frame_cnt_reg    <= frame_cnt_next;
      shots_left_reg   <= shots_left_next;
      duck_idx_reg     <= duck_idx_next;
      hits_reg         <= hits_next;
      round_reg        <= round_next;
      // Status flags decoded from the next state so they are registered
      // yet line up with state_reg.
      duck_spawn_reg   <= (state_next == ST_SPAWN);
      duck_active_reg  <= (state_next == ST_FLY);
      duck_falling_reg <= (state_next == ST_FALL);
      dog_show_reg     <= (state_next == ST_ESCAPE);
      game_over_reg    <= (state_next == ST_GAME_OVER);
    end
  end

  assign bus.duck_spawn   = duck_spawn_reg;
  assign bus.duck_active  = duck_active_reg;
  assign bus.duck_falling = duck_falling_reg;
  assign bus.dog_show     = dog_show_reg;
  assign bus.shots_left   = shots_left_reg;
  assign bus.duck_idx     = duck_idx_reg;
  assign bus.hits         = hits_reg;
  assign bus.round        = round_reg;
  assign bus.game_over    = game_over_reg;

endmodule
